// File: rtl/button_input_conditioner_pkg.sv
// Shared definitions for the blackjack player-input front end: button
// indices, default debounce length and the command priority order.
package button_input_conditioner_pkg;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  localparam int CNT_W_DEFAULT    = 20;

  localparam int NUM_BTN    = 4;
  localparam int NUM_CELLS  = 9;
  localparam int BTN_NEXT   = 0;
  localparam int BTN_HIT    = 1;
  localparam int BTN_STAND  = 2;
  localparam int BTN_DOUBLE = 3;
  localparam int SPLIT_IDX  = 4;
  localparam int BET_LSB    = 5;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_NEXT,
    CMD_STAND,
    CMD_HIT,
    CMD_DOUBLE
  } cmd_e;

  // Priority order: next > stand > hit > double; losers are dropped.
  function automatic cmd_e pick_cmd(input logic [NUM_BTN-1:0] ev);
    cmd_e c;
    c = CMD_NONE;
    if      (ev[BTN_NEXT])   c = CMD_NEXT;
    else if (ev[BTN_STAND])  c = CMD_STAND;
    else if (ev[BTN_HIT])    c = CMD_HIT;
    else if (ev[BTN_DOUBLE]) c = CMD_DOUBLE;
    return c;
  endfunction

endpackage

// File: rtl/button_input_conditioner_debounce_cell.sv
// One synchronise-and-debounce cell: two-flop synchroniser, hold counter
// and the accepted (stable) level. The synchronised sample is also exported
// so the top can tell a genuinely released pin from a freshly reset one.
module debounce_cell
  import button_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic sync
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count while the synchronised pin disagrees with the accepted level;
  // any agreement restarts the count, the terminal count flips the level.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == TERM) stable_d = ~stable_q;
      else               cnt_d    = cnt_q + 1'b1;
    end
  end

  // State registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign sync  = s2_q;

endmodule

// File: rtl/button_input_conditioner.sv
// Player-input front end: debounces 4 buttons, the split switch and the
// 4 bet switches, and turns accepted button presses into prioritised
// one-cycle command pulses.
module button_input_conditioner
  import button_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_hit,
  input  logic       btn_stand,
  input  logic       btn_double,
  input  logic       sw_split,
  input  logic [3:0] sw_bet,
  output logic       next_pulse,
  output logic       hit_pulse,
  output logic       stand_pulse,
  output logic       double_pulse,
  output logic [3:0] btn_level,
  output logic       split_level,
  output logic [3:0] bet_value
);

  logic [NUM_CELLS-1:0] raw_vec, lvl_vec, sync_vec;

  assign raw_vec = {sw_bet, sw_split, btn_double, btn_stand, btn_hit, btn_next};

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_vec[i]),
      .level(lvl_vec[i]),
      .sync (sync_vec[i])
    );
  end

  logic [NUM_BTN-1:0] btn_lvl, btn_sync, ev;
  logic [NUM_BTN-1:0] prev_q, prev_d;
  logic [NUM_BTN-1:0] armed_q, armed_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [1:0]         prime_q, prime_d;
  cmd_e               cmd;

  assign btn_lvl  = lvl_vec[NUM_BTN-1:0];
  assign btn_sync = sync_vec[NUM_BTN-1:0];

  // Edge detect, arming and priority select. Reset zeroes the stable bits
  // too, so "debounced low" alone cannot arm a button: arming also needs
  // the synchroniser to have real samples (prime_q) showing the pin low.
  // A button held through reset thus stays disarmed until released.
  always_comb begin
    prime_d = {prime_q[0], 1'b1};
    prev_d  = btn_lvl;
    armed_d = armed_q | ({NUM_BTN{prime_q[1]}} & ~btn_sync & ~btn_lvl);
    ev      = btn_lvl & ~prev_q & armed_q;
    cmd     = pick_cmd(ev);
    pulse_d = '0;
    case (cmd)
      CMD_NEXT:   pulse_d[BTN_NEXT]   = 1'b1;
      CMD_STAND:  pulse_d[BTN_STAND]  = 1'b1;
      CMD_HIT:    pulse_d[BTN_HIT]    = 1'b1;
      CMD_DOUBLE: pulse_d[BTN_DOUBLE] = 1'b1;
      default:    pulse_d             = '0;
    endcase
  end

  // Edge-detect, arm and registered pulse flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      pulse_q <= '0;
    end else begin
      prime_q <= prime_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign next_pulse   = pulse_q[BTN_NEXT];
  assign hit_pulse    = pulse_q[BTN_HIT];
  assign stand_pulse  = pulse_q[BTN_STAND];
  assign double_pulse = pulse_q[BTN_DOUBLE];
  assign btn_level    = btn_lvl;
  assign split_level  = lvl_vec[SPLIT_IDX];
  assign bet_value    = lvl_vec[BET_LSB +: 4];

endmodule

// File: tb/tb_button_input_conditioner.sv
// Bench for button_input_conditioner with a short debounce length.
module tb_button_input_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 0, btn_hit = 0, btn_stand = 0, btn_double = 0, sw_split = 0;
  logic [3:0] sw_bet = '0;
  logic       next_pulse, hit_pulse, stand_pulse, double_pulse, split_level;
  logic [3:0] btn_level, bet_value;

  int checks = 0, failures = 0;
  int cnt_next = 0, cnt_hit = 0, cnt_stand = 0, cnt_double = 0;

  always #5 clk = ~clk;

  button_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_next(btn_next), .btn_hit(btn_hit), .btn_stand(btn_stand), .btn_double(btn_double),
    .sw_split(sw_split), .sw_bet(sw_bet),
    .next_pulse(next_pulse), .hit_pulse(hit_pulse), .stand_pulse(stand_pulse),
    .double_pulse(double_pulse), .btn_level(btn_level), .split_level(split_level),
    .bet_value(bet_value)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Behavioural model: a pin level is accepted once the pin, seen two
  // edges late, has disagreed with the accepted level for DC edges in a
  // row. A button fires on its accepted rise only if it has been observed
  // genuinely released since reset; one winner per cycle by priority.
  bit [8:0] m_hist1, m_hist2, m_lvl;
  int       m_run [9];
  bit [3:0] m_prev, m_arm, m_pulse;
  int       m_age;
  bit       m_valid = 0;

  always @(posedge clk) begin : model
    bit [8:0] pin;
    bit [3:0] ev, np;
    pin = {sw_bet, sw_split, btn_double, btn_stand, btn_hit, btn_next};
    if (reset) begin
      m_hist1 = '0; m_hist2 = '0; m_lvl = '0; m_prev = '0; m_arm = '0; m_pulse = '0;
      m_age = 0; m_valid = 1;
      for (int i = 0; i < 9; i++) m_run[i] = 0;
    end else begin
      ev = m_lvl[3:0] & ~m_prev & m_arm;
      np = '0;
      if      (ev[0]) np = 4'b0001;
      else if (ev[2]) np = 4'b0100;
      else if (ev[1]) np = 4'b0010;
      else if (ev[3]) np = 4'b1000;
      for (int b = 0; b < 4; b++)
        if (m_age >= 2 && !m_hist2[b] && !m_lvl[b]) m_arm[b] = 1;
      m_prev = m_lvl[3:0];
      for (int i = 0; i < 9; i++) begin
        if (m_hist2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_hist2 = m_hist1;
      m_hist1 = pin;
      m_pulse = np;
      if (m_age < 2) m_age++;
    end
  end

  // Per-cycle comparison against the model, plus pulse tallies.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("btn_level", {28'd0, btn_level}, {28'd0, m_lvl[3:0]});
      chk("split_level", {31'd0, split_level}, {31'd0, m_lvl[4]});
      chk("bet_value", {28'd0, bet_value}, {28'd0, m_lvl[8:5]});
      chk("pulses", {28'd0, double_pulse, stand_pulse, hit_pulse, next_pulse}, {28'd0, m_pulse});
      chk("pulse_onehot", ((32'(next_pulse) + 32'(hit_pulse) + 32'(stand_pulse) + 32'(double_pulse)) <= 1), 32'd1);
      cnt_next   += int'(next_pulse);
      cnt_hit    += int'(hit_pulse);
      cnt_stand  += int'(stand_pulse);
      cnt_double += int'(double_pulse);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int b_next, b_hit, b_stand, b_double;
  task automatic mark();
    b_next = cnt_next; b_hit = cnt_hit; b_stand = cnt_stand; b_double = cnt_double;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk("reset_levels", {24'd0, btn_level, bet_value}, 32'd0);
    chk("reset_pulses", {28'd0, next_pulse, hit_pulse, stand_pulse, double_pulse}, 32'd0);
    tick(5);

    // Clean hit press.
    mark();
    btn_hit = 1;
    tick(5);  chk("hit_level_e5", {31'd0, btn_level[1]}, 32'd0);
    tick(1);  chk("hit_level_e6", {31'd0, btn_level[1]}, 32'd1);
              chk("hit_pulse_e6", {31'd0, hit_pulse}, 32'd0);
    tick(1);  chk("hit_pulse_e7", {31'd0, hit_pulse}, 32'd1);
    tick(1);  chk("hit_pulse_e8", {31'd0, hit_pulse}, 32'd0);
    tick(12);
    btn_hit = 0;
    tick(10);
    chk("hit_count", cnt_hit - b_hit, 32'd1);
    chk("hit_others", (cnt_next - b_next) + (cnt_stand - b_stand) + (cnt_double - b_double), 32'd0);

    // Bouncing stand press.
    mark();
    btn_stand = 1; tick(1); btn_stand = 0; tick(1);
    btn_stand = 1; tick(1); btn_stand = 0; tick(1);
    btn_stand = 1;
    tick(6);  chk("stand_pulse_e6", {31'd0, stand_pulse}, 32'd0);
              chk("stand_bounce_none", cnt_stand - b_stand, 32'd0);
    tick(1);  chk("stand_pulse_e7", {31'd0, stand_pulse}, 32'd1);
    tick(10);
    btn_stand = 0;
    tick(10);
    chk("stand_count", cnt_stand - b_stand, 32'd1);

    // Simultaneous next + hit: only next fires.
    mark();
    btn_next = 1; btn_hit = 1;
    tick(15);
    btn_next = 0; btn_hit = 0;
    tick(10);
    chk("simul_next", cnt_next - b_next, 32'd1);
    chk("simul_hit", cnt_hit - b_hit, 32'd0);

    // Switches give levels only.
    mark();
    sw_bet = 4'b1011; sw_split = 1;
    tick(5);  chk("bet_e5", {28'd0, bet_value}, 32'd0);
    tick(1);  chk("bet_e6", {28'd0, bet_value}, 32'd11);
              chk("split_e6", {31'd0, split_level}, 32'd1);
    tick(5);
    chk("sw_no_pulse", (cnt_next - b_next) + (cnt_hit - b_hit) + (cnt_stand - b_stand) + (cnt_double - b_double), 32'd0);

    // Double held through reset.
    mark();
    btn_double = 1; reset = 1;
    tick(2);
    chk("rst2_bet", {28'd0, bet_value}, 32'd0);
    chk("rst2_split", {31'd0, split_level}, 32'd0);
    reset = 0;
    tick(15);
    chk("held_level", {31'd0, btn_level[3]}, 32'd1);
    chk("held_no_pulse", cnt_double - b_double, 32'd0);
    btn_double = 0; tick(10);
    btn_double = 1; tick(12);
    chk("repress_double", cnt_double - b_double, 32'd1);
    btn_double = 0; tick(10);

    // Reset mid-count on a held next button.
    mark();
    btn_next = 1;
    tick(3); reset = 1;
    tick(1); reset = 0;
    tick(20);
    chk("midrst_no_pulse", cnt_next - b_next, 32'd0);
    btn_next = 0; tick(10);
    btn_next = 1; tick(12);
    chk("midrst_repress", cnt_next - b_next, 32'd1);
    btn_next = 0; tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
